// File: rtl/helios_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : helios_stream_arbiter
// Description : Round-robin, transaction-granular sharing of one decoder core's
//               byte streams among N_REQ requesters, with response watchdog.
// Revision    : 1.0 - initial release
// ============================================================================

module helios_stream_arbiter #(
  parameter int N_REQ          = 2,
  parameter int REQ_BYTES      = 4,
  parameter int RSP_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           rsp_data,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [7:0]           core_in_data,
  output logic                 core_in_valid,
  input  logic                 core_in_ready,
  input  logic [7:0]           core_out_data,
  input  logic                 core_out_valid,
  output logic                 core_out_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int c_req_cw = $clog2(REQ_BYTES + 1);
  localparam int c_rsp_cw = $clog2(RSP_BYTES + 1);
  localparam int c_to_cw  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [c_req_cw-1:0] c_req_last = c_req_cw'(REQ_BYTES - 1);
  localparam logic [c_rsp_cw-1:0] c_rsp_last = c_rsp_cw'(RSP_BYTES - 1);
  localparam logic [c_to_cw-1:0]  c_to_last  = c_to_cw'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ID_W-1:0]     c_id_max   = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_grant_id;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [c_req_cw-1:0] r_req_cnt;
  logic [c_rsp_cw-1:0] r_rsp_cnt;
  logic [c_to_cw-1:0]  r_to_cnt;
  logic                r_timeout_err;

  logic [2*N_REQ-1:0]  w_valid_dbl;
  logic [N_REQ-1:0]    w_valid_rot;
  logic                w_found;
  logic [ID_W-1:0]     w_pick;
  int                  w_sum;
  logic [ID_W-1:0]     w_next_ptr;
  logic                w_req_hs;
  logic                w_rsp_hs;

  // Rotating the doubled vector puts rr_ptr at bit 0, so the first set bit
  // upward is the round-robin winner with wrap-around.
  assign w_valid_dbl = {req_valid, req_valid};
  assign w_valid_rot = w_valid_dbl[r_rr_ptr +: N_REQ];

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_valid_rot[k]) begin
        w_found = 1'b1;
        w_sum   = int'(r_rr_ptr) + k;
        if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
        w_pick  = ID_W'(w_sum);
      end
    end
  end

  assign w_next_ptr = (r_grant_id == c_id_max) ? '0 : r_grant_id + 1'b1;
  assign w_req_hs   = core_in_valid && core_in_ready;
  assign w_rsp_hs   = (r_state == S_RSP) && core_out_valid && rsp_ready[r_grant_id];

  // Data paths are combinational pass-throughs of the granted lane.
  always_comb begin
    req_ready      = '0;
    rsp_valid      = '0;
    rsp_data       = '0;
    core_in_data   = '0;
    core_in_valid  = 1'b0;
    core_out_ready = 1'b0;
    case (r_state)
      S_REQ: begin
        core_in_data          = req_data[{r_grant_id, 3'b000} +: 8];
        core_in_valid         = req_valid[r_grant_id];
        req_ready[r_grant_id] = core_in_ready;
      end
      S_RSP: begin
        rsp_data              = core_out_data;
        rsp_valid[r_grant_id] = core_out_valid;
        core_out_ready        = rsp_ready[r_grant_id];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_grant_id    <= '0;
      r_rr_ptr      <= '0;
      r_req_cnt     <= '0;
      r_rsp_cnt     <= '0;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant_id <= w_pick;
            r_req_cnt  <= '0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_req_hs) begin
            if (r_req_cnt == c_req_last) begin
              r_req_cnt <= '0;
              r_rsp_cnt <= '0;
              r_to_cnt  <= '0;
              r_state   <= S_RSP;
            end else begin
              r_req_cnt <= r_req_cnt + 1'b1;
            end
          end
        end
        S_RSP: begin
          if (w_rsp_hs) begin
            r_to_cnt <= '0;
            if (r_rsp_cnt == c_rsp_last) begin
              r_rsp_cnt <= '0;
              r_rr_ptr  <= w_next_ptr;
              r_state   <= S_IDLE;
            end else begin
              r_rsp_cnt <= r_rsp_cnt + 1'b1;
            end
          end else if (TIMEOUT_CYCLES > 0) begin
            // Abort when this idle cycle makes the count reach the limit.
            if (r_to_cnt == c_to_last) begin
              r_timeout_err <= 1'b1;
              r_rsp_cnt     <= '0;
              r_to_cnt      <= '0;
              r_rr_ptr      <= w_next_ptr;
              r_state       <= S_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant_id    = r_grant_id;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire
